i2s_frame_packer: RTL
=====================

Name: i2s_frame_packer

Overview:
- Next-generation I2S front end: generates the I2S bit clock and word select from the system clock.
- Captures mono or stereo samples, decimates them, truncates each to its top bytes, and interleaves periodic sync records.
- Serialises fixed-size records, byte by byte, into an external byte-wide FIFO write port with backpressure.
- Sits between the I2S microphone pins and the SPI readout FIFO. The whole block runs in a single clock domain, with no derived-clock logic.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- I2S_CLK_FREQ, 1_500_000, target i2s_sck frequency in Hz. CLK_DIV = CLK_FREQ/(2*I2S_CLK_FREQ), must be ≥2.
- SAMPLE_BITS, 24, valid MSB-first bits per channel slot, ≤32.
- OUT_BYTES, 2, most-significant bytes kept per sample (1..3, ≤SAMPLE_BITS/8).
- CHANNELS, 2, 1 = left only, 2 = left+right.
- REDUCE_FACTOR, 2, keep one frame in every REDUCE_FACTOR frames (≥1).
- SYNC_PERIOD, 127, a sync record precedes every SYNC_PERIOD-th kept frame.
- SYNC_BYTE, 8'hAA, fill value of sync records.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable.
- i2s_sck  out  1  I2S bit clock.
- i2s_ws  out  1  word select (0 = left, 1 = right).
- i2s_sd  in  1  serial data from the microphone.
- fifo_wr_en  out  1  byte write strobe.
- fifo_wr_data  out  8  byte to write.
- fifo_full  in  1  FIFO full; no write may occur while it is high.
- dropped_frames  out  16  saturating count of kept frames lost to backpressure.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n is low, every register clears immediately:
  - i2s_sck=0, i2s_ws=0, fifo_wr_en=0, fifo_wr_data=0, dropped_frames=0.
  - All counters cleared; FSM in IDLE.
- Clock generation:
  - Divider counts 0..CLK_DIV-1 and toggles i2s_sck on wrap, giving a period of 2*CLK_DIV clk.
  - Internal single-cycle strobes: sck_rise (sck 0→1) and sck_fall (sck 1→0).
- Framing:
  - 6-bit bit counter advances on each sck_fall; one frame = 64 sck.
  - i2s_ws = bit_cnt[5], updated on sck_fall.
  - Philips alignment: slot bit k (k=1..SAMPLE_BITS after a ws edge) is sampled on sck_rise, MSB first, into the left or right shift register.
- Frame completion: when bit_cnt wraps 63→0, a frame strobe fires and both channel words are latched. With CHANNELS=1 the right slot is ignored.
- Decimation:
  - Frame counter 0..REDUCE_FACTOR-1; a frame is kept when the counter is 0.
  - The first complete frame after enable rises or reset releases is kept.
- Sync scheduling: kept-frame counter 0..SYNC_PERIOD-1. A kept frame with counter 0 (including the first) is preceded by a sync record of FRAME_BYTES = OUT_BYTES*CHANNELS bytes, each equal to SYNC_BYTE.
- Byte order inside a data record:
  - Left channel first, then right.
  - Within a channel, the top OUT_BYTES bytes of the SAMPLE_BITS word, least significant kept byte first.
- Write FSM:
  - IDLE → SYNC (if a sync is due) or DATA on a kept frame.
  - SYNC → DATA after FRAME_BYTES bytes.
  - DATA → IDLE after FRAME_BYTES bytes.
  - Byte index advances only on an accepted write.
- Write handshake: fifo_wr_en = (state≠IDLE) & !fifo_full, combinational. fifo_wr_data is driven from the snapshot register, never from the live shift registers.
- Backpressure:
  - While fifo_full is high, the FSM holds its byte; no byte is skipped or duplicated.
  - A kept frame arriving while state≠IDLE is dropped whole, and dropped_frames increments, saturating at 16'hFFFF.
  - Decimation and sync counters still advance as if the frame had been written, so the sync cadence is unaffected.
- enable low:
  - Divider halts; i2s_sck and i2s_ws are forced to 0; bit counter, frame counter and sync counter clear; partial capture is discarded.
  - An in-progress record still completes. enable high restarts from bit 0 of a new frame.
- Latency: first byte of a record is offered on the clk after the frame strobe.

Test Plan:
- Sim params CLK_FREQ=8, I2S_CLK_FREQ=1 (CLK_DIV=4), enable high → i2s_sck period 8 clk; i2s_ws high for 32 consecutive sck periods, low for 32.
- CHANNELS=2, OUT_BYTES=2, REDUCE_FACTOR=1, SYNC_PERIOD large; BFM drives left 24'h123456, right 24'hABCDEF → first record AA AA AA AA, then 34 12 CD AB on 4 consecutive clks.
- REDUCE_FACTOR=2; frames with left=1,2,3,4 (<<8) → only frames 1 and 3 are written.
- SYNC_PERIOD=3, REDUCE_FACTOR=1, 4 frames D0..D3 → byte stream S D0 D1 D2 S D3, with S = 4×8'hAA.
- fifo_full high for 5 clks mid-record → fifo_wr_en=0 throughout, and the stream resumes with the exact next byte. fifo_full held across a full frame → dropped_frames=1, next record complete and byte-aligned.
- rst_n asserted mid-record, asynchronously between clk edges → all outputs 0 immediately; after release the first record is a sync record.

Source files
------------

// File: rtl/i2s_frame_packer.sv
// I2S receiver and record packer: derives sck/ws from clk, captures Philips-aligned
// samples, decimates, truncates and writes sync/data records into a byte FIFO.
module i2s_frame_packer #(
    parameter int         CLK_FREQ      = 100_000_000,
    parameter int         I2S_CLK_FREQ  = 1_500_000,
    parameter int         SAMPLE_BITS   = 24,
    parameter int         OUT_BYTES     = 2,
    parameter int         CHANNELS      = 2,
    parameter int         REDUCE_FACTOR = 2,
    parameter int         SYNC_PERIOD   = 127,
    parameter logic [7:0] SYNC_BYTE     = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        i2s_sck,
    output logic        i2s_ws,
    input  logic        i2s_sd,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    input  logic        fifo_full,
    output logic [15:0] dropped_frames
);

    localparam int CLK_DIV     = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int FRAME_BYTES = OUT_BYTES * CHANNELS;
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W        = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;
    localparam int SC_W        = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam int BI_W        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int LOW_BIT     = SAMPLE_BITS - 8 * OUT_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_e;

    logic [DIV_W-1:0]         div_q, div_d;
    logic                     sck_q, sck_d;
    logic                     ws_q, ws_d;
    logic [5:0]               bit_q, bit_d;
    logic [SAMPLE_BITS-1:0]   sr_l_q, sr_l_d;
    logic [SAMPLE_BITS-1:0]   sr_r_q, sr_r_d;
    logic [FC_W-1:0]          frame_cnt_q, frame_cnt_d;
    logic [SC_W-1:0]          kept_cnt_q, kept_cnt_d;
    state_e                   state_q, state_d;
    logic [BI_W-1:0]          byte_idx_q, byte_idx_d;
    logic [FRAME_BYTES*8-1:0] snap_q, snap_d;
    logic [15:0]              dropped_q, dropped_d;

    logic       div_wrap;
    logic       sck_rise;
    logic       sck_fall;
    logic       frame_stb;
    logic       keep;
    logic       sync_due;
    logic [5:0] bit_inc;

    assign div_wrap  = (div_q == DIV_W'(CLK_DIV - 1));
    assign sck_rise  = enable && div_wrap && !sck_q;
    assign sck_fall  = enable && div_wrap && sck_q;
    assign bit_inc   = bit_q + 6'd1;
    assign frame_stb = sck_fall && (bit_q == 6'd63);
    assign keep      = frame_stb && (frame_cnt_q == '0);
    assign sync_due  = (kept_cnt_q == '0);

    // Bit-clock generation, framing, capture and the decimation/sync counters.
    always_comb begin
        div_d       = div_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        bit_d       = bit_q;
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
        frame_cnt_d = frame_cnt_q;
        kept_cnt_d  = kept_cnt_q;
        if (!enable) begin
            div_d       = '0;
            sck_d       = 1'b0;
            ws_d        = 1'b0;
            bit_d       = '0;
            sr_l_d      = '0;
            sr_r_d      = '0;
            frame_cnt_d = '0;
            kept_cnt_d  = '0;
        end else begin
            if (div_wrap) begin
                div_d = '0;
                sck_d = !sck_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            if (sck_fall) begin
                bit_d = bit_inc;
                ws_d  = bit_inc[5];
            end
            // Slot bit k (1..SAMPLE_BITS) after a ws edge lands MSB first.
            if (sck_rise) begin
                for (int k = 0; k < SAMPLE_BITS; k++) begin
                    if (int'(bit_q[4:0]) == SAMPLE_BITS - k) begin
                        if (!bit_q[5]) begin
                            sr_l_d[k] = i2s_sd;
                        end else if (CHANNELS == 2) begin
                            sr_r_d[k] = i2s_sd;
                        end
                    end
                end
            end
            if (frame_stb) begin
                if (frame_cnt_q == FC_W'(REDUCE_FACTOR - 1)) begin
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
            end
            // Counts kept frames even when they are dropped, keeping the sync cadence.
            if (keep) begin
                if (kept_cnt_q == SC_W'(SYNC_PERIOD - 1)) begin
                    kept_cnt_d = '0;
                end else begin
                    kept_cnt_d = kept_cnt_q + SC_W'(1);
                end
            end
        end
    end

    assign fifo_wr_en = (state_q != IDLE) && !fifo_full;

    // Record writer: snapshot on a kept frame, then emit sync and/or data bytes.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        dropped_d  = dropped_q;
        case (state_q)
            IDLE: begin
                if (keep) begin
                    byte_idx_d = '0;
                    state_d    = sync_due ? SYNC : DATA;
                    for (int c = 0; c < CHANNELS; c++) begin
                        for (int j = 0; j < OUT_BYTES; j++) begin
                            if (c == 0) begin
                                snap_d[(c*OUT_BYTES + j)*8 +: 8] = sr_l_q[LOW_BIT + 8*j +: 8];
                            end else begin
                                snap_d[(c*OUT_BYTES + j)*8 +: 8] = sr_r_q[LOW_BIT + 8*j +: 8];
                            end
                        end
                    end
                end
            end
            default: begin
                if (fifo_wr_en) begin
                    if (byte_idx_q == BI_W'(FRAME_BYTES - 1)) begin
                        byte_idx_d = '0;
                        state_d    = (state_q == SYNC) ? DATA : IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + BI_W'(1);
                    end
                end
                if (keep && (dropped_q != 16'hFFFF)) begin
                    dropped_d = dropped_q + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        fifo_wr_data = 8'h00;
        if (state_q == SYNC) begin
            fifo_wr_data = SYNC_BYTE;
        end else if (state_q == DATA) begin
            for (int b = 0; b < FRAME_BYTES; b++) begin
                if (byte_idx_q == BI_W'(b)) begin
                    fifo_wr_data = snap_q[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            bit_q       <= '0;
            sr_l_q      <= '0;
            sr_r_q      <= '0;
            frame_cnt_q <= '0;
            kept_cnt_q  <= '0;
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            snap_q      <= '0;
            dropped_q   <= '0;
        end else begin
            div_q       <= div_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            bit_q       <= bit_d;
            sr_l_q      <= sr_l_d;
            sr_r_q      <= sr_r_d;
            frame_cnt_q <= frame_cnt_d;
            kept_cnt_q  <= kept_cnt_d;
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            snap_q      <= snap_d;
            dropped_q   <= dropped_d;
        end
    end

    assign i2s_sck        = sck_q;
    assign i2s_ws         = ws_q;
    assign dropped_frames = dropped_q;

endmodule
